mips_hazard_ctl: RTL and testbench

- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Drives the decode-to-execute register's flush_e input, and the stall enables for the fetch PC and fetch-to-decode registers.
- Drives forwarding mux selects for the D and E stages.
- Owns sequential state:
  - busy countdown for the multi-cycle mult/div unit;
  - done pulse for that unit;
  - saturating stall-cycle performance counter.

---
 rtl/mips_hazard_ctl.sv | 100 ++++++++++
 tb/tb_mips_hazard_ctl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mips_hazard_ctl.sv
// Hazard detection and forwarding control for the 5-stage MIPS pipeline,
// with mult/div busy tracking and a saturating stall-cycle counter.
module mips_hazard_ctl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic             branch_d,
    input  logic             mduse_d,
    input  logic [4:0]       rs_e,
    input  logic [4:0]       rt_e,
    input  logic [4:0]       writereg_e,
    input  logic             regwrite_e,
    input  logic [1:0]       memtoreg_e,
    input  logic             mdstart_e,
    input  logic [4:0]       writereg_m,
    input  logic             regwrite_m,
    input  logic [1:0]       memtoreg_m,
    input  logic [4:0]       writereg_w,
    input  logic             regwrite_w,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             forward_ad,
    output logic             forward_bd,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY);

    logic [3:0] md_cnt;
    logic       lwstall;
    logic       branchstall;
    logic       mdstall;
    logic       stall;

    assign md_busy = (md_cnt != '0);

    always_comb begin
        lwstall     = (memtoreg_e == 2'b01) && (rt_e != '0) &&
                      ((rt_e == rs_d) || (rt_e == rt_d));
        branchstall = branch_d &&
                      ((regwrite_e && (writereg_e != '0) &&
                        ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
                       ((memtoreg_m == 2'b01) && (writereg_m != '0) &&
                        ((writereg_m == rs_d) || (writereg_m == rt_d))));
        mdstall     = mduse_d && (md_busy || mdstart_e);
        stall       = lwstall || branchstall || mdstall;
    end

    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_e    = 1'b0;
        forward_ad = 1'b0;
        forward_bd = 1'b0;
        forward_ae = 2'b00;
        forward_be = 2'b00;
        if (!reset) begin
            stall_f    = stall;
            stall_d    = stall;
            flush_e    = stall;
            forward_ad = regwrite_m && (writereg_m == rs_d) && (rs_d != '0);
            forward_bd = regwrite_m && (writereg_m == rt_d) && (rt_d != '0);
            // M-stage result takes priority over W-stage result
            if (regwrite_m && (writereg_m == rs_e) && (rs_e != '0))
                forward_ae = 2'b10;
            else if (regwrite_w && (writereg_w == rs_e) && (rs_e != '0))
                forward_ae = 2'b01;
            if (regwrite_m && (writereg_m == rt_e) && (rt_e != '0))
                forward_be = 2'b10;
            else if (regwrite_w && (writereg_w == rt_e) && (rt_e != '0))
                forward_be = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt       <= '0;
            md_done      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (mdstart_e)
                md_cnt <= MD_LOAD;
            else if (md_cnt != '0)
                md_cnt <= md_cnt - 4'd1;
            md_done <= (md_cnt == 4'd1) && !mdstart_e;
            if (stall_d && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mips_hazard_ctl.sv
// Self-checking bench for mips_hazard_ctl: directed hazard scenarios then
// randomized traffic, all compared against a cycle-indexed reference model.
module tb_mips_hazard_ctl;

    localparam int L  = 4;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic          branch_d, mduse_d, regwrite_e, mdstart_e, regwrite_m, regwrite_w;
    logic [1:0]    memtoreg_e, memtoreg_m;
    logic          stall_f, stall_d, flush_e, forward_ad, forward_bd;
    logic [1:0]    forward_ae, forward_be;
    logic          md_busy, md_done;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int fails  = 0;
    int cyc_n;
    int last_start;
    int scnt;

    mips_hazard_ctl #(.MD_LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .mduse_d(mduse_d),
        .rs_e(rs_e), .rt_e(rt_e), .writereg_e(writereg_e), .regwrite_e(regwrite_e),
        .memtoreg_e(memtoreg_e), .mdstart_e(mdstart_e),
        .writereg_m(writereg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
        .writereg_w(writereg_w), .regwrite_w(regwrite_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .forward_ad(forward_ad), .forward_bd(forward_bd),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd_e(input logic [4:0] src);
        if (src == 0) return 2'b00;
        if (regwrite_m && writereg_m == src) return 2'b10;
        if (regwrite_w && writereg_w == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        reset = 0; rs_d = 0; rt_d = 0; branch_d = 0; mduse_d = 0;
        rs_e = 0; rt_e = 0; writereg_e = 0; regwrite_e = 0; memtoreg_e = 0;
        mdstart_e = 0; writereg_m = 0; regwrite_m = 0; memtoreg_m = 0;
        writereg_w = 0; regwrite_w = 0;
    endtask

    // Inputs are driven just after a falling edge; check mid-cycle, then
    // advance the model past the coming rising edge.
    task automatic cycle();
        bit busy, done, lw, br, md, st;
        #1;
        busy = (cyc_n > last_start) && (cyc_n <= last_start + L);
        done = (cyc_n == last_start + L + 1);
        lw = (memtoreg_e == 2'b01) && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
        br = branch_d &&
             ((regwrite_e && writereg_e != 0 && (writereg_e == rs_d || writereg_e == rt_d)) ||
              (memtoreg_m == 2'b01 && writereg_m != 0 && (writereg_m == rs_d || writereg_m == rt_d)));
        md = mduse_d && (busy || mdstart_e);
        st = !reset && (lw || br || md);
        chk("stall_f", 32'(stall_f), 32'(st));
        chk("stall_d", 32'(stall_d), 32'(st));
        chk("flush_e", 32'(flush_e), 32'(st));
        chk("forward_ad", 32'(forward_ad),
            32'(!reset && regwrite_m && rs_d != 0 && writereg_m == rs_d));
        chk("forward_bd", 32'(forward_bd),
            32'(!reset && regwrite_m && rt_d != 0 && writereg_m == rt_d));
        chk("forward_ae", 32'(forward_ae), reset ? 32'd0 : 32'(ref_fwd_e(rs_e)));
        chk("forward_be", 32'(forward_be), reset ? 32'd0 : 32'(ref_fwd_e(rt_e)));
        chk("md_busy", 32'(md_busy), 32'(busy));
        chk("md_done", 32'(md_done), 32'(done));
        chk("stall_cycles", 32'(stall_cycles), 32'(scnt));
        if (reset) begin
            last_start = -1000;
            scnt = 0;
        end else begin
            if (mdstart_e) last_start = cyc_n;
            if (st && scnt < SAT) scnt++;
        end
        cyc_n++;
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        cyc_n = 0; last_start = -1000; scnt = 0;
        reset = 1; cycle();
        idle(); cycle();

        // ALU forwarding: M beats W, W alone, register 0 never forwarded
        rs_e = 5; writereg_m = 5; regwrite_m = 1; writereg_w = 5; regwrite_w = 1;
        cycle();
        chk("plan1_m", 32'(forward_ae), 32'd2);
        regwrite_m = 0; cycle();
        rs_e = 0; writereg_m = 0; regwrite_m = 1; writereg_w = 0; cycle();

        // load-use, then load to r0
        idle(); memtoreg_e = 2'b01; rt_e = 8; rs_d = 8; cycle();
        idle(); cycle();
        chk("plan2_cnt", 32'(stall_cycles), 32'd1);
        memtoreg_e = 2'b01; rt_e = 0; rs_d = 0; cycle();

        // branch hazards: ALU producer in E, then in M; load producer E then M
        idle(); branch_d = 1; rs_d = 3; regwrite_e = 1; writereg_e = 3; cycle();
        regwrite_e = 0; writereg_e = 0; writereg_m = 3; regwrite_m = 1; cycle();
        regwrite_m = 0; writereg_m = 0;
        regwrite_e = 1; writereg_e = 3; memtoreg_e = 2'b01; cycle();
        regwrite_e = 0; writereg_e = 0; memtoreg_e = 0;
        writereg_m = 3; regwrite_m = 1; memtoreg_m = 2'b01; cycle();
        idle(); cycle();

        // mult/div start with dependent op held in D
        mduse_d = 1; mdstart_e = 1; cycle();
        mdstart_e = 0;
        for (int i = 0; i < L + 2; i++) cycle();
        mduse_d = 0; cycle();

        // reset in the middle of a mult/div
        mdstart_e = 1; cycle();
        mdstart_e = 0; cycle();
        reset = 1; rs_e = 7; writereg_m = 7; regwrite_m = 1; mduse_d = 1; cycle();
        idle(); for (int i = 0; i < L + 2; i++) cycle();

        // long load-use stall saturates the counter
        memtoreg_e = 2'b01; rt_e = 8; rs_d = 8;
        for (int i = 0; i < (1 << CW) + 5; i++) cycle();
        idle(); cycle();
        chk("sat", 32'(stall_cycles), 32'(SAT));
        reset = 1; cycle();

        // randomized traffic, including restarts while busy
        for (int i = 0; i < 500; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            rs_d       = 5'($urandom_range(0, 3));
            rt_d       = 5'($urandom_range(0, 3));
            branch_d   = 1'($urandom_range(0, 1));
            mduse_d    = ($urandom_range(0, 3) == 0);
            rs_e       = 5'($urandom_range(0, 3));
            rt_e       = 5'($urandom_range(0, 3));
            writereg_e = 5'($urandom_range(0, 3));
            regwrite_e = 1'($urandom_range(0, 1));
            memtoreg_e = 2'($urandom);
            mdstart_e  = ($urandom_range(0, 7) == 0);
            writereg_m = 5'($urandom_range(0, 3));
            regwrite_m = 1'($urandom_range(0, 1));
            memtoreg_m = 2'($urandom);
            writereg_w = 5'($urandom_range(0, 3));
            regwrite_w = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
